matmul_stream_unit: RTL and testbench

- Parametrised successor to the fixed 8x8 vector-lane matmul unit: LANES x LANES systolic-free row-streaming matrix multiplier with configurable inner dimension K, accumulate mode and abort.
- Sits beside the vector lanes: B rows are loaded over the lane bus, then A rows are streamed one per beat, and one C row is returned per beat to vector writeback along with the captured dst/we/mask metadata.
- Asserts stall while an operation is in flight.

---
 rtl/matmul_stream_pkg.sv | 16 +
 rtl/matmul_col_mac.sv | 66 ++++++
 rtl/matmul_stream_unit.sv | 170 +++++++++++++++++
 tb/tb_matmul_stream_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_stream_pkg.sv
// Shared types for the row-streaming matmul unit.
// FSM states and index-width helper.
package matmul_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_B,
    STREAM_A,
    DRAIN
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_col_mac.sv
// One output column: registered products, then
// registered column sum plus accumulator element.
module matmul_col_mac
  import matmul_stream_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DWIDTH = 32,
  parameter int RW     = idx_w(LANES)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic [LANES-1:0][DWIDTH-1:0]  a_row,
  input  logic [LANES-1:0][DWIDTH-1:0]  b_col,
  input  logic [DWIDTH-1:0]             acc,
  input  logic                          in_valid,
  input  logic [RW-1:0]                 in_tag,
  output logic                          out_valid,
  output logic [RW-1:0]                 out_tag,
  output logic [DWIDTH-1:0]             out_sum
);

  logic [LANES-1:0][DWIDTH-1:0] prod_q;
  logic [DWIDTH-1:0]            acc_q;
  logic [DWIDTH-1:0]            sum_d;
  logic                         v1_q;
  logic [RW-1:0]                t1_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prod_q <= '0;
      acc_q  <= '0;
      v1_q   <= 1'b0;
      t1_q   <= '0;
    end else begin
      v1_q <= in_valid & ~flush;
      if (in_valid) begin
        t1_q  <= in_tag;
        acc_q <= acc;
        for (int k = 0; k < LANES; k++)
          prod_q[k] <= a_row[k] * b_col[k];
      end
    end
  end

  always_comb begin
    sum_d = acc_q;
    for (int k = 0; k < LANES; k++)
      sum_d = sum_d + prod_q[k];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_sum   <= '0;
    end else begin
      out_valid <= v1_q & ~flush;
      if (v1_q) begin
        out_tag <= t1_q;
        out_sum <= sum_d;
      end
    end
  end

endmodule

// File: rtl/matmul_stream_unit.sv
// Row-streaming LANES x LANES matmul beside the vector lanes:
// load B rows, stream A rows, return one C row per beat.
module matmul_stream_unit
  import matmul_stream_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DWIDTH = 32,
  parameter int DSTW   = 8,
  parameter int KW     = $clog2(LANES+1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    acc_mode,
  input  logic [KW-1:0]           dim,
  input  logic [DSTW-1:0]         in_dst,
  input  logic                    in_dst_we,
  input  logic [LANES-1:0]        vmask,
  input  logic                    in_valid,
  input  logic [LANES*DWIDTH-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [LANES*DWIDTH-1:0] out_data,
  output logic [$clog2(LANES)-1:0] out_row,
  output logic [DSTW-1:0]         out_dst,
  output logic                    out_dst_we,
  output logic [LANES-1:0]        out_dst_mask,
  output logic                    done,
  output logic                    stall
);

  localparam int RW = idx_w(LANES);

  typedef logic [LANES-1:0][DWIDTH-1:0] row_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_eff;
  logic [RW-1:0]     cnt_q;
  logic              acc_q, we_q;
  logic              iss_q, done_q;
  logic              beat, last_beat, go, issue;
  row_t              b_buf   [LANES];
  row_t              acc_buf [LANES];
  row_t              b_col   [LANES];
  row_t              row_in, a_msk, c_row;
  logic [DWIDTH-1:0] acc_el  [LANES];
  logic [DWIDTH-1:0] sum_arr [LANES];
  logic [RW-1:0]     tag     [LANES];
  logic [LANES-1:0]  vld;
  logic [RW-1:0]     row_d;

  assign row_in    = in_data;
  assign k_eff     = (dim == '0 || dim > KW'(LANES))
                   ? KW'(LANES) : dim;
  assign in_ready  = (state_q == LOAD_B) |
                     (state_q == STREAM_A);
  assign stall     = (state_q != IDLE);
  assign beat      = in_valid & in_ready;
  assign last_beat = (KW'(cnt_q) == k_q - KW'(1));
  assign go        = start & ~abort & (state_q == IDLE);
  assign issue     = beat & ~abort &
                     (state_q == STREAM_A);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (go) state_d = LOAD_B;
      LOAD_B:   if (beat && last_beat)
                  state_d = STREAM_A;
      STREAM_A: if (beat && last_beat)
                  state_d = DRAIN;
      DRAIN:    if (!iss_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      acc_q        <= 1'b0;
      we_q         <= 1'b0;
      out_dst      <= '0;
      out_dst_mask <= '0;
      iss_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= issue;
      // stage 1 is empty, so the row on stage 2 is the last one
      done_q  <= (state_q == DRAIN) & ~iss_q & ~abort;
      if (go) begin
        k_q          <= k_eff;
        acc_q        <= acc_mode;
        we_q         <= in_dst_we;
        out_dst      <= in_dst;
        out_dst_mask <= vmask;
        cnt_q        <= '0;
      end else if (beat) begin
        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < LANES; r++) begin
        b_buf[r]   <= '0;
        acc_buf[r] <= '0;
      end
    end else begin
      if (go) begin
        for (int r = 0; r < LANES; r++)
          b_buf[r] <= '0;
      end else if (beat && state_q == LOAD_B) begin
        b_buf[cnt_q] <= row_in;
      end
      if (out_valid) acc_buf[out_row] <= c_row;
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++)
      a_msk[k] = (KW'(k) < k_q) ? row_in[k] : '0;
    for (int j = 0; j < LANES; j++) begin
      for (int k = 0; k < LANES; k++)
        b_col[j][k] = b_buf[k][j];
      acc_el[j] = acc_q ? acc_buf[cnt_q][j] : '0;
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_col
    matmul_col_mac #(
      .LANES  (LANES),
      .DWIDTH (DWIDTH),
      .RW     (RW)
    ) u_mac (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (abort),
      .a_row     (a_msk),
      .b_col     (b_col[j]),
      .acc       (acc_el[j]),
      .in_valid  (issue),
      .in_tag    (cnt_q),
      .out_valid (vld[j]),
      .out_tag   (tag[j]),
      .out_sum   (sum_arr[j])
    );
  end

  // every column carries identical valid/tag
  always_comb begin
    row_d = '1;
    for (int j = 0; j < LANES; j++) begin
      row_d    = row_d & tag[j];
      c_row[j] = sum_arr[j];
    end
  end

  assign out_valid  = &vld;
  assign out_row    = row_d;
  assign out_data   = c_row;
  assign out_dst_we = we_q & out_valid;
  assign done       = done_q;

endmodule

// File: tb/tb_matmul_stream_unit.sv
// Randomised bench for matmul_stream_unit against
// a plain-arithmetic matrix model.
module tb_matmul_stream_unit;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0, abort = 1'b0;
  logic         acc_mode = 1'b0;
  logic [3:0]   dim = '0;
  logic [7:0]   in_dst = '0;
  logic         in_dst_we = 1'b0;
  logic [7:0]   vmask = '0;
  logic         in_valid = 1'b0;
  logic [255:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [255:0] out_data;
  logic [2:0]   out_row;
  logic [7:0]   out_dst, out_dst_mask;
  logic         out_dst_we, done, stall;

  matmul_stream_unit dut (
    .clk(clk), .resetn(resetn), .start(start),
    .abort(abort), .acc_mode(acc_mode), .dim(dim),
    .in_dst(in_dst), .in_dst_we(in_dst_we),
    .vmask(vmask), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_row(out_row), .out_dst(out_dst),
    .out_dst_we(out_dst_we),
    .out_dst_mask(out_dst_mask),
    .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0, n_done = 0, we_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] a_m   [8][8];
  logic [31:0] b_m   [8][8];
  logic [31:0] acc_m [8][8];

  int           q_row[$], q_cyc[$], q_we[$];
  int           q_dst[$], q_mask[$];
  logic [255:0] q_data[$];

  always @(negedge clk) if (resetn) begin
    if (out_valid) begin
      q_row.push_back(int'(out_row));
      q_data.push_back(out_data);
      q_cyc.push_back(cyc);
      q_we.push_back(int'(out_dst_we));
      q_dst.push_back(int'(out_dst));
      q_mask.push_back(int'(out_dst_mask));
    end
    if (done) n_done++;
    if (out_dst_we && !out_valid) we_bad++;
  end

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack_a(int i);
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = a_m[i][j];
    return v;
  endfunction

  function automatic logic [255:0] pack_b(int r);
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = b_m[r][j];
    return v;
  endfunction

  // C[i][j] = acc + sum over k<K of A[i][k]*B[k][j], mod 2^32
  function automatic logic [255:0] exp_row(int i, int k,
                                           bit accm);
    logic [255:0] v;
    logic [31:0]  s;
    for (int j = 0; j < 8; j++) begin
      s = accm ? acc_m[i][j] : 32'd0;
      for (int kk = 0; kk < k; kk++)
        s = s + a_m[i][kk] * b_m[kk][j];
      v[j*32 +: 32] = s;
    end
    return v;
  endfunction

  function automatic int eff_k(int d);
    return (d == 0 || d > 8) ? 8 : d;
  endfunction

  task automatic clear_q();
    q_row.delete(); q_data.delete(); q_cyc.delete();
    q_we.delete(); q_dst.delete(); q_mask.delete();
  endtask

  task automatic send_beat(input logic [255:0] d,
                           output int at);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    at = -1;
    while (at < 0 && n < 10) begin
      @(negedge clk);
      n++;
      if (in_ready) at = cyc;
    end
    if (at < 0) check("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic kick(input int d, input bit accm,
                      input logic [7:0] dst, input bit we,
                      input logic [7:0] mask);
    @(posedge clk); #1;
    start = 1'b1; dim = d[3:0]; acc_mode = accm;
    in_dst = dst; in_dst_we = we; vmask = mask;
    @(posedge clk); #1;
    start = 1'b0;
    check("stall_busy", stall, 1);
  endtask

  task automatic run_op(input int d, input bit accm,
                        input logic [7:0] dst, input bit we,
                        input logic [7:0] mask);
    int k, c, dcyc, n, m;
    int bc[8];
    logic [255:0] e[8];
    k = eff_k(d);
    for (int i = 0; i < k; i++) e[i] = exp_row(i, k, accm);
    clear_q();
    kick(d, accm, dst, we, mask);
    for (int r = 0; r < k; r++) send_beat(pack_b(r), c);
    for (int i = 0; i < k; i++) send_beat(pack_a(i), bc[i]);
    dcyc = -1; n = 0;
    while (dcyc < 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (done) begin
        dcyc = cyc;
        check("stall_at_done", stall, 0);
      end
    end
    check("done_lat", dcyc, bc[k-1] + 3);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("nrows", q_row.size(), k);
    m = (q_row.size() < k) ? q_row.size() : k;
    for (int i = 0; i < m; i++) begin
      check($sformatf("row%0d_idx", i), q_row[i], i);
      check($sformatf("row%0d_data", i), q_data[i], e[i]);
      check($sformatf("row%0d_lat", i), q_cyc[i], bc[i] + 2);
      check($sformatf("row%0d_meta", i),
            {q_we[i][0], q_dst[i][7:0], q_mask[i][7:0]},
            {we, dst, mask});
    end
    for (int i = 0; i < k; i++)
      for (int j = 0; j < 8; j++)
        acc_m[i][j] = e[i][j*32 +: 32];
  endtask

  task automatic rand_mats();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        a_m[i][j] = $urandom;
        b_m[i][j] = $urandom;
      end
  endtask

  task automatic ident_mats();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        b_m[i][j] = (i == j) ? 32'd1 : 32'd0;
        a_m[i][j] = 32'(8 * i + j + 1);
      end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_ctl"},
          {out_valid, out_row, out_dst, out_dst_we,
           out_dst_mask, done, stall, in_ready}, 0);
  endtask

  initial begin
    int nd0, c;
    int bc[2];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) acc_m[i][j] = '0;
    #12;
    check_idle("por");
    @(posedge clk); #1;
    resetn = 1'b1;

    ident_mats();
    run_op(8, 0, 8'h11, 1, 8'hA5);
    run_op(8, 1, 8'h22, 0, 8'h3C);

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        b_m[i][j] = 32'd2;
        a_m[i][j] = (j < 3) ? 32'd1 : 32'hDEAD;
      end
    run_op(3, 0, 8'h33, 1, 8'hFF);
    check("partial_val", q_data.size() > 0 ? q_data[0] : '0,
          {8{32'd6}});

    a_m[0][0] = 32'hFFFF_FFFF;
    for (int j = 0; j < 8; j++) b_m[0][j] = 32'd2;
    run_op(1, 0, 8'h44, 1, 8'h01);
    check("wrap_val", q_data.size() > 0 ? q_data[0] : '0,
          {8{32'hFFFF_FFFE}});

    for (int t = 0; t < 6; t++) begin
      rand_mats();
      run_op($urandom_range(0, 15), 1'($urandom_range(0, 1)),
             8'($urandom), 1'($urandom_range(0, 1)),
             8'($urandom));
    end

    rand_mats();
    clear_q();
    nd0 = n_done;
    kick(8, 0, 8'h55, 1, 8'hF0);
    for (int r = 0; r < 8; r++) send_beat(pack_b(r), c);
    for (int i = 0; i < 2; i++) send_beat(pack_a(i), bc[i]);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_stall", stall, 0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_rows", q_row.size() <= 2, 1);
    check("abort_done", n_done - nd0, 0);
    for (int i = 0; i < q_row.size() && i < 2; i++) begin
      check("abort_idx", q_row[i], i);
      check("abort_data", q_data[i], exp_row(i, 8, 0));
    end

    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", stall, 0);

    kick(8, 0, 8'h66, 1, 8'h0F);
    for (int r = 0; r < 3; r++) send_beat(pack_b(r), c);
    #2;
    resetn = 1'b0;
    #1;
    check_idle("rst_mid");
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) acc_m[i][j] = '0;

    rand_mats();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        b_m[i][j] = (i == j) ? 32'd1 : 32'd0;
    run_op(8, 1, 8'h77, 1, 8'hC3);
    for (int i = 0; i < q_data.size() && i < 8; i++)
      check("post_rst_eq_a", q_data[i], pack_a(i));

    check("we_unqualified", we_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1);
  end

endmodule
